// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
// Sequencing front-end for a 16-bit ripple adder that updates its 32-bit
// zero-extended sum on the rising edge of its count strobe. The block:
//   - accepts one operand pair at a time over a valid/ready handshake,
//   - drives the adder operands and strobe from registers so they are glitch-free,
//   - captures the adder sum and presents it downstream over valid/ready,
//   - counts completed output handshakes and flags a malformed adder output.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_a       operand A (16)
//   in_b       operand B (16)
//   in_ready   block can accept an operand pair (IDLE only)
//   add_a      registered operand A, to the adder's A (16)
//   add_b      registered operand B, to the adder's B (16)
//   add_count  registered strobe, to the adder's count
//   add_sum    adder result (32)
//   out_valid  result valid (HOLD only)
//   out_sum    captured adder result (32)
//   out_err    captured add_sum[31:17] was nonzero
//   out_ready  downstream accepts the result
//   op_count   completed output handshakes, wraps (16)

module adder_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_count,
  input  logic [31:0] add_sum,
  output logic        out_valid,
  output logic [31:0] out_sum,
  output logic        out_err,
  input  logic        out_ready,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    STROBE,
    CAPTURE,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addA_q, addA_d;
  logic [15:0] addB_q, addB_d;
  logic [31:0] outSum_q, outSum_d;
  logic        outErr_q, outErr_d;
  logic [15:0] opCount_q, opCount_d;
  logic        inReady_q, inReady_d;
  logic        outValid_q, outValid_d;
  logic        addCount_q, addCount_d;

  // Next-state and datapath decisions. The handshake flags and the strobe are
  // decoded from the *next* state so that, once registered, each one is high
  // exactly while the FSM sits in its state and never depends on an input
  // combinationally.
  always_comb begin
    state_d   = state_q;
    addA_d    = addA_q;
    addB_d    = addB_q;
    outSum_d  = outSum_q;
    outErr_d  = outErr_q;
    opCount_d = opCount_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addA_d  = in_a;
          addB_d  = in_b;
          state_d = DRIVE;
        end
      end
      DRIVE:   state_d = STROBE;
      STROBE:  state_d = CAPTURE;
      CAPTURE: begin
        // The adder has had a full cycle since the strobe edge to settle.
        // Bits above 16 can never be set by a 16+16 add, so any of them
        // being high means the adder output is malformed.
        outSum_d = add_sum;
        outErr_d = |add_sum[31:17];
        state_d  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          opCount_d = opCount_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    inReady_d  = (state_d == IDLE);
    outValid_d = (state_d == HOLD);
    addCount_d = (state_d == STROBE);
  end

  // All state lives here. Reset takes priority over everything, including a
  // HOLD handshake, so a reset in STROBE drops the strobe on that same edge
  // and the in-flight result is simply lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addA_q     <= 16'd0;
      addB_q     <= 16'd0;
      outSum_q   <= 32'd0;
      outErr_q   <= 1'b0;
      opCount_q  <= 16'd0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      addCount_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addA_q     <= addA_d;
      addB_q     <= addB_d;
      outSum_q   <= outSum_d;
      outErr_q   <= outErr_d;
      opCount_q  <= opCount_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
      addCount_q <= addCount_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign add_count = addCount_q;
  assign add_a     = addA_q;
  assign add_b     = addB_q;
  assign out_sum   = outSum_q;
  assign out_err   = outErr_q;
  assign op_count  = opCount_q;

endmodule
